// File: rtl/flags_stack_unit.sv
// NZCV status-flag register with a LIFO flag stack for interrupt context save/restore.
// Optional FLAGS_DIRECT_WR_EN adds a direct flag load port (flags_wr/flags_din).
module flags_stack_unit #(
    parameter int unsigned WIDTH       = 12,
    parameter int unsigned STACK_DEPTH = 4,
    parameter logic [3:0]  OP_ADD      = 4'b1001,
    parameter logic [3:0]  OP_SUB      = 4'b1010,
    parameter logic [3:0]  OP_CMP      = 4'b0100,
    parameter logic [3:0]  OP_AND      = 4'b1000
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flag_we,
    input  logic [3:0]                           opcode,
    input  logic [WIDTH-1:0]                     op1,
    input  logic [WIDTH-1:0]                     op2,
    input  logic [WIDTH-1:0]                     result,
    input  logic                                 push,
    input  logic                                 pop,
    input  logic                                 err_clr,
`ifdef FLAGS_DIRECT_WR_EN
    input  logic                                 flags_wr,
    input  logic [3:0]                           flags_din,
`endif
    output logic                                 N,
    output logic                                 Z,
    output logic                                 C,
    output logic                                 V,
    output logic [$clog2(STACK_DEPTH+1)-1:0]     stk_count,
    output logic                                 stk_full,
    output logic                                 stk_empty,
    output logic                                 stk_err
);

    localparam int unsigned CW  = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int unsigned MSB = WIDTH - 1;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    nzcv_t          flags_q;
    nzcv_t          flags_d;
    nzcv_t          alu_flags;
    nzcv_t          stack_q [STACK_DEPTH];
    logic [CW-1:0]  count_q;
    logic [CW-1:0]  count_d;
    logic           err_q;
    logic           err_d;
    logic           op_match;
    logic [WIDTH:0] add_sum;
    logic           full;
    logic           empty;
    logic           push_ok;
    logic           pop_only;
    logic           pop_ok;
    logic           err_set;
    logic [IW-1:0]  push_idx;
    logic [IW-1:0]  pop_idx;

    assign full  = (count_q == CW'(STACK_DEPTH));
    assign empty = (count_q == '0);

    // Candidate flags from the ALU operands; C/V hold for logical ops.
    always_comb begin
        alu_flags   = flags_q;
        op_match    = 1'b0;
        add_sum     = {1'b0, op1} + {1'b0, op2};
        alu_flags.n = result[MSB];
        alu_flags.z = (result == '0);
        if (opcode == OP_ADD) begin
            op_match    = 1'b1;
            alu_flags.c = add_sum[WIDTH];
            alu_flags.v = (op1[MSB] == op2[MSB]) && (result[MSB] != op1[MSB]);
        end else if ((opcode == OP_SUB) || (opcode == OP_CMP)) begin
            op_match    = 1'b1;
            alu_flags.c = (op1 >= op2);
            alu_flags.v = (op1[MSB] != op2[MSB]) && (result[MSB] != op1[MSB]);
        end else if (opcode == OP_AND) begin
            op_match    = 1'b1;
        end
    end

    // Stack control: simultaneous push and pop is an error and leaves the stack alone.
    always_comb begin
        push_ok  = push && !pop && !full;
        pop_only = pop && !push;
        pop_ok   = pop_only && !empty;
        err_set  = (push && pop) || (push && !pop && full) || (pop_only && empty);
        push_idx = IW'(count_q);
        pop_idx  = IW'(count_q - CW'(1));
    end

    // Next-state selection: pop beats direct load beats ALU update.
    always_comb begin
        flags_d = flags_q;
        count_d = count_q;
        err_d   = err_q;

        if (pop_only) begin
            if (pop_ok) begin
                flags_d = stack_q[pop_idx];
            end
        end
`ifdef FLAGS_DIRECT_WR_EN
        else if (flags_wr) begin
            flags_d = nzcv_t'(flags_din);
        end
`endif
        else if (flag_we && op_match) begin
            flags_d = alu_flags;
        end

        if (push_ok) begin
            count_d = count_q + CW'(1);
        end else if (pop_ok) begin
            count_d = count_q - CW'(1);
        end

        if (err_set) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Stack storage carries no reset; stale entries are never observable.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            stack_q[push_idx] <= flags_q;
        end
    end

    assign N         = flags_q.n;
    assign Z         = flags_q.z;
    assign C         = flags_q.c;
    assign V         = flags_q.v;
    assign stk_count = count_q;
    assign stk_full  = full;
    assign stk_empty = empty;
    assign stk_err   = err_q;

endmodule
